// File: rtl/comb_gates_4_input_pkg.sv
// comb_gates_4_input_pkg: result bundle, reset value and reduction helper for the 4-input gate block
package comb_gates_4_input_pkg;
  typedef struct packed {
    logic g_and;
    logic g_nand;
    logic g_or;
    logic g_nor;
  } gates_t;
  localparam gates_t GATES_RST = '{g_and: 1'b0, g_nand: 1'b1, g_or: 1'b0, g_nor: 1'b1};
  function automatic gates_t reduce4(input logic [3:0] v);
    return '{g_and: &v, g_nand: ~&v, g_or: |v, g_nor: ~|v};
  endfunction
endpackage

// File: rtl/comb_gates_4_input.sv
// comb_gates_4_input: AND/NAND/OR/NOR of four inputs, combinational plus registered copies
module comb_gates_4_input
  import comb_gates_4_input_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic in0,
  input  logic in1,
  input  logic in2,
  input  logic in3,
  output logic out_and,
  output logic out_nand,
  output logic out_or,
  output logic out_nor,
  output logic out_and_q,
  output logic out_nand_q,
  output logic out_or_q,
  output logic out_nor_q
);
  gates_t gates_d, gates_q;
  always_comb gates_d = reduce4({in3, in2, in1, in0});
  always_ff @(posedge clk)
    gates_q <= reset ? GATES_RST : gates_d;
  assign {out_and, out_nand, out_or, out_nor} = gates_d;
  assign {out_and_q, out_nand_q, out_or_q, out_nor_q} = gates_q;
endmodule

// File: tb/tb_comb_gates_4_input.sv
// tb_comb_gates_4_input: scoreboard bench for the 4-input gate block
module tb_comb_gates_4_input;
  logic clk = 1'b0;
  logic reset, in0, in1, in2, in3;
  logic out_and, out_nand, out_or, out_nor;
  logic out_and_q, out_nand_q, out_or_q, out_nor_q;
  int tests = 0;
  int fails = 0;
  logic [3:0] sb[$];
  logic [3:0] exp_q, obs_c, obs_q;

  comb_gates_4_input dut (
    .clk(clk), .reset(reset),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .out_and(out_and), .out_nand(out_nand), .out_or(out_or), .out_nor(out_nor),
    .out_and_q(out_and_q), .out_nand_q(out_nand_q), .out_or_q(out_or_q), .out_nor_q(out_nor_q)
  );

  always #5 clk = ~clk;

  assign obs_c = {out_and, out_nand, out_or, out_nor};
  assign obs_q = {out_and_q, out_nand_q, out_or_q, out_nor_q};

  // expected {and,nand,or,nor} from the truth table: and only for 1111, or zero only for 0000
  function automatic logic [3:0] model(input logic [3:0] v);
    logic a, o;
    a = (v == 4'b1111);
    o = (v != 4'b0000);
    return {a, !a, o, !o};
  endfunction

  // drive just after an edge, queue what the next edge must register, then settle 8 units
  task automatic drive(input logic [3:0] v, input logic r);
    {in0, in1, in2, in3} = v;
    reset = r;
    sb.push_back(r ? 4'b0101 : model(v));
    #8;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      drive(4'b1111, 1'b1);
      tests++;
      if (obs_c !== 4'b1010) begin fails++; $display("FAIL reset_comb cyc%0d got %b want 1010", i, obs_c); end
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      tests++;
      if (obs_q !== exp_q) begin fails++; $display("FAIL reset_q cyc%0d got %b want %b", i, obs_q, exp_q); end
    end
    drive(4'b1111, 1'b0);
    @(posedge clk); #1;
    exp_q = sb.pop_front();
    tests++;
    if (obs_q !== exp_q || obs_q !== 4'b1010) begin fails++; $display("FAIL reset_release_q got %b want 1010", obs_q); end
  endtask

  task automatic test_sweep();
    for (int v = 0; v < 16; v++) begin
      drive(4'(v), 1'b0);
      tests++;
      if (obs_c !== model(4'(v))) begin fails++; $display("FAIL sweep_comb %b got %b want %b", 4'(v), obs_c, model(4'(v))); end
      tests++;
      if (out_nand !== ~out_and || out_nor !== ~out_or || (out_and && !out_or))
        begin fails++; $display("FAIL sweep_invariant %b got %b", 4'(v), obs_c); end
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      tests++;
      if (obs_q !== exp_q) begin fails++; $display("FAIL sweep_q %b got %b want %b", 4'(v), obs_q, exp_q); end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] seq [2] = '{4'b0000, 4'b1111};
    logic [3:0] want [2] = '{4'b0101, 4'b1010};
    for (int i = 0; i < 2; i++) begin
      drive(seq[i], 1'b0);
      tests++;
      if (obs_q === want[i] && i == 1) begin fails++; $display("FAIL latency_early got %b want %b", obs_q, want[0]); end
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      tests++;
      if (obs_q !== want[i] || obs_q !== exp_q) begin fails++; $display("FAIL latency_q step%0d got %b want %b", i, obs_q, want[i]); end
    end
  endtask

  task automatic test_single_hot();
    logic [3:0] pats [4] = '{4'b0100, 4'b0010, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      drive(pats[i], 1'b0);
      tests++;
      if (obs_c !== 4'b0110) begin fails++; $display("FAIL single_hot %b got %b want 0110", pats[i], obs_c); end
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      tests++;
      if (obs_q !== exp_q) begin fails++; $display("FAIL single_hot_q %b got %b want %b", pats[i], obs_q, exp_q); end
    end
  endtask

  task automatic test_mid_reset();
    logic [3:0] rs = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      drive(4'b1111, rs[i]);
      tests++;
      if (obs_c !== 4'b1010) begin fails++; $display("FAIL midreset_comb step%0d got %b want 1010", i, obs_c); end
      @(posedge clk); #1;
      exp_q = sb.pop_front();
      tests++;
      if (obs_q !== exp_q) begin fails++; $display("FAIL midreset_q step%0d got %b want %b", i, obs_q, exp_q); end
    end
  endtask

  initial begin
    reset = 1'b1;
    {in0, in1, in2, in3} = 4'b0000;
    @(posedge clk); #1;
    test_reset();
    test_sweep();
    test_back_to_back();
    test_single_hot();
    test_mid_reset();
    tests++;
    if (sb.size() != 0) begin fails++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "timeout");
  end
endmodule
